// File: rtl/fp32_pkg.sv
// Shared types and constants for the binary32 handshake adder.
package fp32_pkg;

  localparam int unsigned EXP_W  = 10;
  localparam int unsigned MANT_W = 27;

  localparam logic signed [EXP_W-1:0] EXP_BIAS = 10'sd127;
  localparam logic signed [EXP_W-1:0] EXP_MIN  = -10'sd126;
  localparam logic signed [EXP_W-1:0] EXP_MAX  = 10'sd127;
  localparam logic signed [EXP_W-1:0] ALIGN_MAX = 10'sd26;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef enum logic [3:0] {
    GET_A,
    GET_B,
    UNPACK,
    SPECIAL,
    ALIGN,
    ADD0,
    ADD1,
    NORM1,
    NORM2,
    ROUND,
    PACK,
    PUT_Z
  } state_e;

  // exp is the raw unbiased field (-127 for a zero exponent field);
  // mant carries hidden bit, fraction and three guard/round/sticky zeros.
  typedef struct packed {
    logic                    sign;
    logic signed [EXP_W-1:0] exp;
    logic [MANT_W-1:0]       mant;
    logic                    is_nan;
    logic                    is_inf;
    logic                    is_zero;
    logic                    is_sub;
  } fp_unpacked_t;

endpackage

// File: rtl/fp32_unpack.sv
// Splits a binary32 word into sign, unbiased exponent, extended mantissa and class flags.
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0]  x_i,
  output fp_unpacked_t u_o
);

  logic [7:0]  exp_field;
  logic [22:0] frac;

  assign exp_field = x_i[30:23];
  assign frac      = x_i[22:0];

  always_comb begin
    u_o         = '0;
    u_o.sign    = x_i[31];
    u_o.exp     = $signed({2'b00, exp_field}) - EXP_BIAS;
    u_o.mant    = {(exp_field != 8'h00), frac, 3'b000};
    u_o.is_nan  = (exp_field == 8'hFF) && (frac != '0);
    u_o.is_inf  = (exp_field == 8'hFF) && (frac == '0);
    u_o.is_zero = (exp_field == 8'h00) && (frac == '0);
    u_o.is_sub  = (exp_field == 8'h00) && (frac != '0);
  end

endmodule

// File: rtl/fp32_add_hs.sv
// Sequential IEEE-754 binary32 adder with stb/ack handshakes, one add in flight.
// Define FP32_ADD_DENORM_EN for gradual underflow; otherwise subnormals flush to signed zero.
module fp32_add_hs
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  state_e state_q, state_d;

  logic [31:0]             a_q, a_d, b_q, b_d, z_q, z_d;
  logic                    a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
  logic                    a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
  logic signed [EXP_W-1:0] a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
  logic [MANT_W-1:0]       a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
  logic [MANT_W:0]         sum_q, sum_d;
  logic [7:0]              exp_field;

  fp_unpacked_t ua, ub;
  logic         a_zero, b_zero;

  fp32_unpack u_unpack_a (.x_i(a_q), .u_o(ua));
  fp32_unpack u_unpack_b (.x_i(b_q), .u_o(ub));

`ifdef FP32_ADD_DENORM_EN
  assign a_zero = ua.is_zero;
  assign b_zero = ub.is_zero;
`else
  assign a_zero = ua.is_zero | ua.is_sub;
  assign b_zero = ub.is_zero | ub.is_sub;
`endif

  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign output_z     = z_q;
  assign output_z_stb = z_stb_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    z_d       = z_q;
    a_ack_d   = a_ack_q;
    b_ack_d   = b_ack_q;
    z_stb_d   = z_stb_q;
    a_s_d     = a_s_q;
    b_s_d     = b_s_q;
    z_s_d     = z_s_q;
    a_e_d     = a_e_q;
    b_e_d     = b_e_q;
    z_e_d     = z_e_q;
    a_m_d     = a_m_q;
    b_m_d     = b_m_q;
    z_m_d     = z_m_q;
    sum_d     = sum_q;
    exp_field = 8'(z_e_q + EXP_BIAS);

    unique case (state_q)
      GET_A: begin
        a_ack_d = 1'b1;
        if (a_ack_q && input_a_stb) begin
          a_d     = input_a;
          a_ack_d = 1'b0;
          state_d = GET_B;
        end
      end
      GET_B: begin
        b_ack_d = 1'b1;
        if (b_ack_q && input_b_stb) begin
          b_d     = input_b;
          b_ack_d = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        a_s_d   = ua.sign;
        a_e_d   = ua.is_sub ? EXP_MIN : ua.exp;
        a_m_d   = ua.mant;
        b_s_d   = ub.sign;
        b_e_d   = ub.is_sub ? EXP_MIN : ub.exp;
        b_m_d   = ub.mant;
        state_d = SPECIAL;
      end
      SPECIAL: begin
        state_d = PUT_Z;
        z_stb_d = 1'b1;
        if (ua.is_nan || ub.is_nan) begin
          z_d = QNAN;
        end else if (ua.is_inf) begin
          z_d = (ub.is_inf && (ua.sign != ub.sign)) ? QNAN : (ua.sign ? NEG_INF : POS_INF);
        end else if (ub.is_inf) begin
          z_d = ub.sign ? NEG_INF : POS_INF;
        end else if (a_zero && b_zero) begin
          z_d = {ua.sign & ub.sign, 31'b0};
        end else if (a_zero) begin
          z_d = b_q;
        end else if (b_zero) begin
          z_d = a_q;
        end else begin
          state_d = ALIGN;
          z_stb_d = 1'b0;
        end
      end
      ALIGN: begin
        // Bits shifted out are OR-ed into bit 0 so it always means "something below was nonzero".
        if (a_e_q > b_e_q) begin
          if ((a_e_q - b_e_q) > ALIGN_MAX) begin
            b_m_d = {{(MANT_W-1){1'b0}}, |b_m_q};
            b_e_d = a_e_q;
          end else begin
            b_m_d = {1'b0, b_m_q[MANT_W-1:2], b_m_q[1] | b_m_q[0]};
            b_e_d = b_e_q + 10'sd1;
          end
        end else if (b_e_q > a_e_q) begin
          if ((b_e_q - a_e_q) > ALIGN_MAX) begin
            a_m_d = {{(MANT_W-1){1'b0}}, |a_m_q};
            a_e_d = b_e_q;
          end else begin
            a_m_d = {1'b0, a_m_q[MANT_W-1:2], a_m_q[1] | a_m_q[0]};
            a_e_d = a_e_q + 10'sd1;
          end
        end else begin
          state_d = ADD0;
        end
      end
      ADD0: begin
        z_e_d = a_e_q;
        if (a_s_q == b_s_q) begin
          sum_d = {1'b0, a_m_q} + {1'b0, b_m_q};
          z_s_d = a_s_q;
        end else if (a_m_q >= b_m_q) begin
          sum_d = {1'b0, a_m_q - b_m_q};
          z_s_d = a_s_q;
        end else begin
          sum_d = {1'b0, b_m_q - a_m_q};
          z_s_d = b_s_q;
        end
        state_d = ADD1;
      end
      ADD1: begin
        if (sum_q[MANT_W]) begin
          z_m_d = {sum_q[MANT_W:2], sum_q[1] | sum_q[0]};
          z_e_d = z_e_q + 10'sd1;
        end else begin
          z_m_d = sum_q[MANT_W-1:0];
        end
        state_d = NORM1;
      end
      NORM1: begin
        // An exact-zero difference is left alone instead of shifting down to EXP_MIN.
        if (!z_m_q[MANT_W-1] && (z_e_q > EXP_MIN) && (z_m_q != '0)) begin
          z_m_d = {z_m_q[MANT_W-2:0], 1'b0};
          z_e_d = z_e_q - 10'sd1;
        end else begin
`ifdef FP32_ADD_DENORM_EN
          state_d = NORM2;
`else
          state_d = ROUND;
`endif
        end
      end
      NORM2: begin
`ifdef FP32_ADD_DENORM_EN
        if (z_e_q < EXP_MIN) begin
          z_m_d = {1'b0, z_m_q[MANT_W-1:2], z_m_q[1] | z_m_q[0]};
          z_e_d = z_e_q + 10'sd1;
        end else begin
          state_d = ROUND;
        end
`else
        state_d = ROUND;
`endif
      end
      ROUND: begin
        if (z_m_q[2] && (z_m_q[1] | z_m_q[0] | z_m_q[3])) begin
          if (&z_m_q[MANT_W-1:3]) begin
            z_m_d = {1'b1, {(MANT_W-1){1'b0}}};
            z_e_d = z_e_q + 10'sd1;
          end else begin
            z_m_d = {z_m_q[MANT_W-1:3] + 24'd1, 3'b000};
          end
        end
        state_d = PACK;
      end
      PACK: begin
        z_stb_d = 1'b1;
        state_d = PUT_Z;
        if (z_e_q > EXP_MAX) begin
          z_d = z_s_q ? NEG_INF : POS_INF;
        end else if (z_m_q[MANT_W-1:3] == '0) begin
          z_d = '0;
        end else if ((z_e_q == EXP_MIN) && !z_m_q[MANT_W-1]) begin
`ifdef FP32_ADD_DENORM_EN
          z_d = {z_s_q, 8'h00, z_m_q[MANT_W-2:3]};
`else
          z_d = {z_s_q, 31'b0};
`endif
        end else begin
          z_d = {z_s_q, exp_field, z_m_q[MANT_W-2:3]};
        end
      end
      PUT_Z: begin
        if (output_z_ack) begin
          z_stb_d = 1'b0;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
      a_s_q   <= 1'b0;
      b_s_q   <= 1'b0;
      z_s_q   <= 1'b0;
      a_e_q   <= '0;
      b_e_q   <= '0;
      z_e_q   <= '0;
      a_m_q   <= '0;
      b_m_q   <= '0;
      z_m_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      z_stb_q <= z_stb_d;
      a_s_q   <= a_s_d;
      b_s_q   <= b_s_d;
      z_s_q   <= z_s_d;
      a_e_q   <= a_e_d;
      b_e_q   <= b_e_d;
      z_e_q   <= z_e_d;
      a_m_q   <= a_m_d;
      b_m_q   <= b_m_d;
      z_m_q   <= z_m_d;
      sum_q   <= sum_d;
    end
  end

endmodule

// File: tb/tb_fp32_add_hs.sv
// Bench for fp32_add_hs: directed cases, handshake/reset behaviour and random ops vs an exact-arithmetic model.
module tb_fp32_add_hs;

`ifdef FP32_ADD_DENORM_EN
  localparam bit DENORM = 1'b1;
`else
  localparam bit DENORM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a, input_b;
  logic        input_a_stb, input_b_stb, input_a_ack, input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb, output_z_ack;

  int n_cmp = 0;
  int n_bad = 0;

  fp32_add_hs dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: operands become exact integers in units of 2^-149, summed, then rounded to nearest even.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]          ea, eb;
    logic [22:0]         fa, fb;
    logic                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sz;
    logic [299:0]        ma, mb, mag, kept, rem, half, one;
    logic signed [300:0] va, vb, vs;
    int                  p, sh, bexp;
    ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
    a_nan  = (ea == 8'hFF) && (fa != 0);
    b_nan  = (eb == 8'hFF) && (fb != 0);
    a_inf  = (ea == 8'hFF) && (fa == 0);
    b_inf  = (eb == 8'hFF) && (fb == 0);
    a_zero = (ea == 8'h00) && ((fa == 0) || !DENORM);
    b_zero = (eb == 8'h00) && ((fb == 0) || !DENORM);
    if (a_nan || b_nan) return 32'h7FC00000;
    if (a_inf && b_inf) return (a[31] != b[31]) ? 32'h7FC00000 : a;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_zero && b_zero) return {a[31] & b[31], 31'b0};
    if (a_zero) return b;
    if (b_zero) return a;
    ma = 300'({ea != 8'h00, fa}) << ((ea == 8'h00) ? 0 : int'(ea) - 1);
    mb = 300'({eb != 8'h00, fb}) << ((eb == 8'h00) ? 0 : int'(eb) - 1);
    va = {1'b0, ma};
    vb = {1'b0, mb};
    if (a[31]) va = -va;
    if (b[31]) vb = -vb;
    vs  = va + vb;
    sz  = vs[300];
    mag = sz ? 300'(-vs) : 300'(vs);
    if (mag == 0) return 32'h0;
    p = 0;
    for (int i = 299; i >= 0; i--) begin
      if (mag[i]) begin
        p = i;
        break;
      end
    end
    if (p <= 23) begin
      if (!DENORM && p < 23) return {sz, 31'b0};
      return {sz, mag[30:0]};
    end
    one  = 300'd1;
    sh   = p - 23;
    kept = mag >> sh;
    rem  = mag & ((one << sh) - one);
    half = one << (sh - 1);
    if ((rem > half) || ((rem == half) && kept[0])) kept = kept + one;
    if (kept[24]) begin
      kept = kept >> 1;
      sh   = sh + 1;
    end
    bexp = sh + 1;
    if (bexp >= 255) return {sz, 8'hFF, 23'b0};
    return {sz, 8'(bexp), kept[22:0]};
  endfunction

  task automatic send_a(input logic [31:0] v, output bit ok);
    int n;
    input_a = v; input_a_stb = 1'b1; n = 0;
    while (input_a_ack !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
    ok = (input_a_ack === 1'b1);
    @(negedge clk);
    input_a_stb = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] v, output bit ok);
    int n;
    input_b = v; input_b_stb = 1'b1; n = 0;
    while (input_b_ack !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
    ok = (input_b_ack === 1'b1);
    @(negedge clk);
    input_b_stb = 1'b0;
  endtask

  task automatic get_z(output logic [31:0] z, output bit ok);
    int n;
    output_z_ack = 1'b0; n = 0;
    while (output_z_stb !== 1'b1 && n < 200) begin
      @(negedge clk); n++;
    end
    ok = (output_z_stb === 1'b1);
    z = output_z;
    output_z_ack = 1'b1;
    @(negedge clk);
    output_z_ack = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_z);
    bit ok_a, ok_b, ok_z;
    logic [31:0] z;
    send_a(a, ok_a);
    send_b(b, ok_b);
    get_z(z, ok_z);
    n_cmp++;
    if (!(ok_a && ok_b && ok_z)) begin
      n_bad++;
      $display("FAIL %s handshake timeout a=%h b=%h (ack_a=%0d ack_b=%0d stb_z=%0d, required all 1)",
               name, a, b, ok_a, ok_b, ok_z);
    end else if (z !== exp_z) begin
      n_bad++;
      $display("FAIL %s %h + %h: got %h, expected %h", name, a, b, z, exp_z);
    end
  endtask

  task automatic test_reset();
    bit b_early;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (output_z !== 32'h0) begin n_bad++; $display("FAIL reset_z got %h expected 00000000", output_z); end
    n_cmp++; if (output_z_stb !== 1'b0) begin n_bad++; $display("FAIL reset_stb got %b expected 0", output_z_stb); end
    n_cmp++; if (input_a_ack !== 1'b0) begin n_bad++; $display("FAIL reset_a_ack got %b expected 0", input_a_ack); end
    n_cmp++; if (input_b_ack !== 1'b0) begin n_bad++; $display("FAIL reset_b_ack got %b expected 0", input_b_ack); end
    input_b = 32'h3F800000; input_b_stb = 1'b1;
    rst = 1'b0;
    b_early = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (input_b_ack !== 1'b0) b_early = 1'b1;
    end
    n_cmp++; if (b_early) begin n_bad++; $display("FAIL b_before_a b_ack seen 1, expected 0 while A pending"); end
    n_cmp++; if (input_a_ack !== 1'b1) begin n_bad++; $display("FAIL a_ack_after_reset got %b expected 1", input_a_ack); end
    input_b_stb = 1'b0;
  endtask

  task automatic test_directed();
    run_op("dir_2.5-1.5", 32'h40200000, 32'hBFC00000, 32'h3F800000);
    run_op("dir_1+1",     32'h3F800000, 32'h3F800000, 32'h40000000);
    run_op("dir_ovf",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    run_op("dir_inf-inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000);
    run_op("dir_inf+1",   32'h7F800000, 32'h3F800000, 32'h7F800000);
    run_op("dir_cancel",  32'h3F800000, 32'hBF800000, 32'h00000000);
    run_op("dir_tie_even",32'h4B800000, 32'h3F800000, 32'h4B800000);
    run_op("dir_round_up",32'h4B800000, 32'h40000000, 32'h4B800001);
    run_op("dir_nan",     32'h7FC12345, 32'h3F800000, 32'h7FC00000);
    run_op("dir_negzero", 32'h80000000, 32'h80000000, 32'h80000000);
    run_op("dir_mixzero", 32'h80000000, 32'h00000000, 32'h00000000);
    run_op("dir_zero+x",  32'h00000000, 32'hC1200000, 32'hC1200000);
    run_op("dir_denorm",  32'h00000001, 32'h00000001, DENORM ? 32'h00000002 : 32'h00000000);
  endtask

  task automatic test_hold_stb();
    int n;
    bit held;
    rst = 1'b1; output_z_ack = 1'b0;
    @(negedge clk);
    input_a = 32'h40200000; input_a_stb = 1'b1;
    input_b = 32'hBFC00000; input_b_stb = 1'b1;
    rst = 1'b0;
    n = 0;
    while (output_z_stb !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
    end
    input_a_stb = 1'b0; input_b_stb = 1'b0;
    n_cmp++; if (n > 20) begin n_bad++; $display("FAIL hold_latency got %0d cycles, required <= 20", n); end
    n_cmp++; if (output_z !== 32'h3F800000) begin n_bad++; $display("FAIL hold_result got %h expected 3f800000", output_z); end
    held = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (output_z_stb !== 1'b1 || output_z !== 32'h3F800000) held = 1'b0;
    end
    n_cmp++; if (!held) begin n_bad++; $display("FAIL hold_stable stb=%b z=%h, expected 1/3f800000", output_z_stb, output_z); end
    output_z_ack = 1'b1;
    @(negedge clk);
    output_z_ack = 1'b0;
    n_cmp++; if (output_z_stb !== 1'b0) begin n_bad++; $display("FAIL hold_release stb got %b expected 0", output_z_stb); end
  endtask

  task automatic test_reset_mid_align();
    bit ok_a, ok_b;
    send_a(32'h4B800000, ok_a);
    send_b(32'h3F800000, ok_b);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (!ok_a || !ok_b || output_z_stb !== 1'b0 || output_z !== 32'h0 ||
        input_a_ack !== 1'b0 || input_b_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_align_reset ok=%0d%0d stb=%b z=%h a_ack=%b b_ack=%b, expected 11/0/00000000/0/0",
               ok_a, ok_b, output_z_stb, output_z, input_a_ack, input_b_ack);
    end
    rst = 1'b0;
    @(negedge clk);
    run_op("after_reset", 32'h40200000, 32'hBFC00000, 32'h3F800000);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [7:0]  e;
    for (int i = 0; i < 250; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: begin
          e = a[30:23] + 8'($urandom_range(0, 30)) - 8'd15;
          b = {1'($urandom), e, 23'($urandom)};
        end
        2: b = {~a[31], a[30:0]} ^ 32'($urandom_range(0, 255));
        default: begin
          a = {1'($urandom), 8'($urandom_range(0, 3)), 23'($urandom)};
          b = {1'($urandom), 8'($urandom_range(0, 3)), 23'($urandom)};
        end
      endcase
      run_op("random", a, b, ref_add(a, b));
    end
  endtask

  initial begin
    rst = 1'b1;
    input_a = '0; input_b = '0;
    input_a_stb = 1'b0; input_b_stb = 1'b0; output_z_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_hold_stb();
    test_reset_mid_align();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
